// File: rtl/seg_scan_bcd.sv
// Two-digit multiplexed common-anode 7-segment driver for a BCD seconds counter.
// Synchronises inputs, captures whole frames tear-free, blanks a leading zero and blinks a latched overflow dp.
module seg_scan_bcd #(
    parameter int SCAN_DIV      = 50_000,
    parameter int BLINK_TICKS   = 250,
    parameter int LEADING_BLANK = 1
) (
    input  logic       clk_50MHz,
    input  logic       clr,
    input  logic [3:0] high,
    input  logic [3:0] low,
    input  logic       cn,
    output logic [6:0] seg,
    output logic       dp,
    output logic [1:0] an
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [PW-1:0] PS_MAX = PW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BL_MAX = BW'(BLINK_TICKS - 1);

    typedef enum logic [1:0] {S_LOW, S_GAP0, S_HIGH, S_GAP1} state_t;

    logic [8:0]    sync1, sync2;      // {cn, high, low}
    logic [7:0]    prev_digits;
    logic          cn_prev;
    logic [PW-1:0] ps_cnt, ps_cnt_n;
    state_t        state, state_n;
    logic [3:0]    shadow_high, shadow_low, shadow_high_n, shadow_low_n;
    logic          ovf, ovf_n;
    logic [BW-1:0] blink_cnt, blink_cnt_n;
    logic          blink_phase, blink_phase_n;
    logic [6:0]    seg_n;
    logic          dp_n;
    logic [1:0]    an_n;
    logic          tick, stable, cn_rise;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    always_comb begin
        tick    = (ps_cnt == PS_MAX);
        stable  = (sync2[7:0] == prev_digits);
        cn_rise = sync2[8] & ~cn_prev;

        ps_cnt_n = tick ? '0 : ps_cnt + PW'(1);

        state_n = state;
        if (tick) begin
            case (state)
                S_LOW:   state_n = S_GAP0;
                S_GAP0:  state_n = S_HIGH;
                S_HIGH:  state_n = S_GAP1;
                default: state_n = S_LOW;
            endcase
        end

        // A frame only loads digits that have settled; otherwise the old frame is repeated whole.
        shadow_high_n = shadow_high;
        shadow_low_n  = shadow_low;
        if (tick && state == S_GAP1 && stable) begin
            shadow_high_n = sync2[7:4];
            shadow_low_n  = sync2[3:0];
        end

        ovf_n         = ovf | cn_rise;
        blink_cnt_n   = '0;
        blink_phase_n = 1'b0;
        if (ovf) begin
            blink_cnt_n   = blink_cnt;
            blink_phase_n = blink_phase;
            if (tick) begin
                if (blink_cnt == BL_MAX) begin
                    blink_cnt_n   = '0;
                    blink_phase_n = ~blink_phase;
                end else begin
                    blink_cnt_n = blink_cnt + BW'(1);
                end
            end
        end

        // Outputs are derived from the next-state values so they track the state with no extra lag.
        seg_n = 7'h7F;
        dp_n  = 1'b1;
        an_n  = 2'b11;
        case (state_n)
            S_LOW: begin
                an_n  = 2'b10;
                seg_n = decode(shadow_low_n);
            end
            S_HIGH: begin
                if (!(LEADING_BLANK != 0 && shadow_high_n == 4'd0)) begin
                    an_n  = 2'b01;
                    seg_n = decode(shadow_high_n);
                    dp_n  = ~(ovf_n & blink_phase_n);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_50MHz or posedge clr) begin
        if (clr) begin
            sync1       <= '0;
            sync2       <= '0;
            prev_digits <= '0;
            cn_prev     <= 1'b0;
            ps_cnt      <= '0;
            state       <= S_LOW;
            shadow_high <= '0;
            shadow_low  <= '0;
            ovf         <= 1'b0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            seg         <= 7'h7F;
            dp          <= 1'b1;
            an          <= 2'b11;
        end else begin
            sync1       <= {cn, high, low};
            sync2       <= sync1;
            prev_digits <= sync2[7:0];
            cn_prev     <= sync2[8];
            ps_cnt      <= ps_cnt_n;
            state       <= state_n;
            shadow_high <= shadow_high_n;
            shadow_low  <= shadow_low_n;
            ovf         <= ovf_n;
            blink_cnt   <= blink_cnt_n;
            blink_phase <= blink_phase_n;
            seg         <= seg_n;
            dp          <= dp_n;
            an          <= an_n;
        end
    end

endmodule

// File: tb/tb_seg_scan_bcd.sv
// Bench for seg_scan_bcd: two instances (leading blank on/off) share stimulus; a scoreboard holds expected displays.
module tb_seg_scan_bcd;

    localparam int SD   = 4;
    localparam int BT   = 2;
    localparam int HMAX = 4096;

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [1:0] an;
    } disp_t;

    typedef struct packed {
        disp_t a;
        disp_t b;
    } exp_t;

    localparam disp_t BLANK = '{seg: 7'h7F, dp: 1'b1, an: 2'b11};
    localparam logic [6:0] SEG_TAB [0:15] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
        7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [3:0] high = '0;
    logic [3:0] low = '0;
    logic       cn = 1'b0;
    logic [6:0] seg_a, seg_b;
    logic       dp_a, dp_b;
    logic [1:0] an_a, an_b;

    always #5 clk = ~clk;

    seg_scan_bcd #(.SCAN_DIV(SD), .BLINK_TICKS(BT), .LEADING_BLANK(1)) dut_a (
        .clk_50MHz(clk), .clr(clr), .high(high), .low(low), .cn(cn),
        .seg(seg_a), .dp(dp_a), .an(an_a));

    seg_scan_bcd #(.SCAN_DIV(SD), .BLINK_TICKS(BT), .LEADING_BLANK(0)) dut_b (
        .clk_50MHz(clk), .clr(clr), .high(high), .low(low), .cn(cn),
        .seg(seg_b), .dp(dp_b), .an(an_b));

    exp_t       sb[$];
    int         compared = 0;
    int         mismatched = 0;

    // Reference model: edge index n since reset release, inputs sampled per edge.
    int         n = 0;
    int         ovf_at = -1;
    logic [7:0] shadow = '0;
    logic [8:0] hist [0:HMAX-1];

    function automatic logic [8:0] past(input int k);
        if (k < 1 || k >= HMAX) return 9'd0;
        return hist[k];
    endfunction

    function automatic disp_t view(input int lb, input int st, input logic [7:0] sh, input logic lit);
        disp_t d;
        d = BLANK;
        if (st == 0) begin
            d.an  = 2'b10;
            d.seg = SEG_TAB[sh[3:0]];
        end else if (st == 2 && !(lb != 0 && sh[7:4] == 4'd0)) begin
            d.an  = 2'b01;
            d.seg = SEG_TAB[sh[7:4]];
            d.dp  = ~lit;
        end
        return d;
    endfunction

    task automatic model_step();
        logic [8:0] cur, prv;
        int         t, st;
        logic       lit;
        exp_t       e;
        cur = past(n - 2);
        prv = past(n - 3);
        if (ovf_at < 0 && cur[8] && !prv[8]) ovf_at = n;
        if (n % (4 * SD) == 0 && cur[7:0] == prv[7:0]) shadow = cur[7:0];
        t   = n / SD;
        st  = t % 4;
        lit = (ovf_at >= 0) && ((((t - ovf_at / SD) / BT) % 2) == 1);
        e.a = view(1, st, shadow, lit);
        e.b = view(0, st, shadow, lit);
        sb.push_back(e);
    endtask

    task automatic drive(input logic [3:0] h, input logic [3:0] l, input logic c);
        high = h;
        low  = l;
        cn   = c;
        if (n + 1 < HMAX) hist[n + 1] = {c, h, l};
        @(posedge clk);
        #1;
        n++;
        model_step();
    endtask

    task automatic do_reset(input int cyc);
        exp_t e;
        e.a = BLANK;
        e.b = BLANK;
        @(posedge clk);
        #2;
        clr = 1'b1;
        sb.push_back(e);
        repeat (cyc) begin
            @(posedge clk);
            #1;
            sb.push_back(e);
        end
        clr    = 1'b0;
        n      = 0;
        ovf_at = -1;
        shadow = '0;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                compared += 2;
                if ({seg_a, dp_a, an_a} !== e.a) begin
                    mismatched++;
                    $display("FAIL blank_on t=%0t got seg=%b dp=%b an=%b want seg=%b dp=%b an=%b",
                             $time, seg_a, dp_a, an_a, e.a.seg, e.a.dp, e.a.an);
                end
                if ({seg_b, dp_b, an_b} !== e.b) begin
                    mismatched++;
                    $display("FAIL blank_off t=%0t got seg=%b dp=%b an=%b want seg=%b dp=%b an=%b",
                             $time, seg_b, dp_b, an_b, e.b.seg, e.b.dp, e.b.an);
                end
            end
        end
    end

    initial begin
        logic [3:0] rh, rl;
        logic       rc;
        do_reset(2);
        repeat (40) drive(4'd4, 4'd7, 1'b0);
        // Change units one cycle ahead of a capture edge: the frame must keep the old digit.
        while ((n + 1) % 16 != 15) drive(4'd4, 4'd5, 1'b0);
        repeat (40) drive(4'd4, 4'd6, 1'b0);
        do_reset(3);
        repeat (40) drive(4'd0, 4'd3, 1'b0);
        repeat (40) drive(4'd0, 4'hC, 1'b0);
        repeat (40) drive(4'hB, 4'd9, 1'b0);
        repeat (100) drive(4'd2, 4'd1, 1'b1);
        repeat (100) drive(4'd2, 4'd1, 1'b0);
        repeat (30) drive(4'd2, 4'd1, 1'b1);
        do_reset(2);
        repeat (40) drive(4'd2, 4'd1, 1'b0);
        // Carry edge and a tens change both land on the capture edge.
        repeat (40) drive(4'd9, 4'd5, 1'b0);
        while ((n + 3) % 16 != 0) drive(4'd9, 4'd5, 1'b0);
        repeat (60) drive(4'd0, 4'd5, 1'b1);
        do_reset(2);
        rh = 4'd1;
        rl = 4'd2;
        rc = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 11) == 0) begin
                rh = 4'($urandom_range(0, 15));
                rl = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 59) == 0) rc = ~rc;
            if ($urandom_range(0, 499) == 0) do_reset(1 + $urandom_range(0, 2));
            drive(rh, rl, rc);
        end
        repeat (3) @(negedge clk);
        #1;
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL drain got %0d pending want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
